// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the mux_sel_arbiter, its requesters and the mux8 select input.
interface mux_sel_arbiter_if #(
   parameter int unsigned N    = 8,
   parameter int unsigned SELW = 3
);
   logic [N-1:0]    req;
   logic            done;
   logic [SELW-1:0] sel;
   logic            sel_valid;
   logic [N-1:0]    grant;
   logic            timeout;

   modport master (input req, done, output sel, sel_valid, grant, timeout);
   modport slave  (output req, done, input sel, sel_valid, grant, timeout);
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the binary select and valid flag of a downstream 8:1 mux.
// Optional forced release after MAX_HOLD cycles: define MUX_SEL_ARB_TIMEOUT_EN.
module mux_sel_arbiter #(
   parameter int unsigned N        = 8,
   parameter int unsigned SELW     = 3,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst,
   mux_sel_arbiter_if.master  bus
);
   localparam int unsigned CNTW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   if (SELW != $clog2(N)) begin : g_bad_selw
      $error("SELW must equal clog2(N)");
   end
   if (MAX_HOLD < 2) begin : g_bad_hold
      $error("MAX_HOLD must be at least 2");
   end

   typedef enum logic [0:0] {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic            valid_q, valid_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [SELW-1:0] last_q, last_d;
   logic            win_found;
   logic [SELW-1:0] win_idx;
   logic [SELW-1:0] cand;
   logic            user_rel;
   logic            force_rel;

`ifdef MUX_SEL_ARB_TIMEOUT_EN
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;
`endif

   // Rotating-priority search starting just after the last winner
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = SELW'((32'(last_q) + i) % N);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      valid_d   = valid_q;
      grant_d   = grant_q;
      last_d    = last_q;
      user_rel  = 1'b0;
      force_rel = 1'b0;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = BUSY;
               sel_d   = win_idx;
               valid_d = 1'b1;
               grant_d = N'(1) << win_idx;
               last_d  = win_idx;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         BUSY: begin
            user_rel = bus.done || !bus.req[sel_q];
`ifdef MUX_SEL_ARB_TIMEOUT_EN
            force_rel = !user_rel && (cnt_q == CNTW'(MAX_HOLD - 1));
`endif
            if (user_rel || force_rel) begin
`ifdef MUX_SEL_ARB_TIMEOUT_EN
               timeout_d = force_rel;
               cnt_d     = '0;
`endif
               // Released channel sits at lowest priority since last == sel
               if (win_found) begin
                  sel_d   = win_idx;
                  grant_d = N'(1) << win_idx;
                  last_d  = win_idx;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  grant_d = '0;
               end
            end else begin
`ifdef MUX_SEL_ARB_TIMEOUT_EN
               cnt_d = cnt_q + CNTW'(1);
`endif
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         valid_q <= 1'b0;
         grant_q <= '0;
         last_q  <= SELW'(N - 1);
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef MUX_SEL_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.sel       = sel_q;
   assign bus.sel_valid = valid_q;
   assign bus.grant     = grant_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: directed vectors queue expected outputs, a monitor compares.
module tb_mux_sel_arbiter;
   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_pass;

   mux_sel_arbiter_if #(.N(8), .SELW(3)) bus ();

   mux_sel_arbiter #(.N(8), .SELW(3), .MAX_HOLD(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         cyc;
      logic [2:0] sel;
      logic       valid;
      logic [7:0] grant;
      logic       to;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation whose target cycle has arrived
   always @(negedge clk or sample_ev) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         if (bus.sel === e.sel && bus.sel_valid === e.valid &&
             bus.grant === e.grant && bus.timeout === e.to) begin
            n_pass++;
         end else begin
            $display("FAIL cyc%0d: got sel=%0d valid=%b grant=%b timeout=%b, want sel=%0d valid=%b grant=%b timeout=%b",
                     cyc, bus.sel, bus.sel_valid, bus.grant, bus.timeout,
                     e.sel, e.valid, e.grant, e.to);
         end
      end
   end

   task automatic expect_at(input int c, input logic [2:0] s, input logic v, input logic to);
      exp_t e;
      e.cyc   = c;
      e.sel   = s;
      e.valid = v;
      e.grant = v ? (8'd1 << s) : 8'd0;
      e.to    = to;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs (called at posedge+1) and expect the result after the next edge
   task automatic step(input logic [7:0] r, input logic d,
                       input logic [2:0] s, input logic v, input logic to);
      bus.req  = r;
      bus.done = d;
      expect_at(cyc + 1, s, v, to);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] s;
      logic       to;
      cyc      = 0;
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      bus.req  = 8'h00;
      bus.done = 1'b0;

      @(posedge clk);
      #1;
      expect_at(cyc, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single request, release via done with request dropped, done while idle
      step(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
      step(8'h04, 1'b0, 3'd2, 1'b1, 1'b0);
      step(8'h00, 1'b1, 3'd2, 1'b0, 1'b0);
      step(8'h00, 1'b0, 3'd2, 1'b0, 1'b0);
      step(8'h00, 1'b1, 3'd2, 1'b0, 1'b0);

      // All requesting, done every cycle: rotation with no valid gap
      step(8'hFF, 1'b0, 3'd3, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         s = 3'((4 + i) % 8);
         step(8'hFF, 1'b1, s, 1'b1, 1'b0);
      end

      // Withdrawal regrant, then withdrawal to idle
      step(8'h40, 1'b0, 3'd6, 1'b1, 1'b0);
      step(8'h00, 1'b0, 3'd6, 1'b0, 1'b0);

      // Wrap-around, hold, simultaneous done+withdraw, held done, ignored other changes
      step(8'h20, 1'b0, 3'd5, 1'b1, 1'b0);
      step(8'h21, 1'b1, 3'd0, 1'b1, 1'b0);
      step(8'h21, 1'b0, 3'd0, 1'b1, 1'b0);
      step(8'h20, 1'b1, 3'd5, 1'b1, 1'b0);
      step(8'h21, 1'b1, 3'd0, 1'b1, 1'b0);
      step(8'h21, 1'b1, 3'd5, 1'b1, 1'b0);
      step(8'hFF, 1'b0, 3'd5, 1'b1, 1'b0);
      step(8'h10, 1'b1, 3'd4, 1'b1, 1'b0);

      // Asynchronous reset while channel 4 is granted
      @(negedge clk);
      #1;
      rst      = 1'b1;
      bus.req  = 8'h90;
      bus.done = 1'b0;
      #1;
      expect_at(cyc, 3'd0, 1'b0, 1'b0);
      ->sample_ev;
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(8'h90, 1'b0, 3'd4, 1'b1, 1'b0);
      step(8'h90, 1'b1, 3'd7, 1'b1, 1'b0);
      step(8'h00, 1'b1, 3'd7, 1'b0, 1'b0);

      // Long hold without done
      step(8'h03, 1'b0, 3'd0, 1'b1, 1'b0);
      for (int k = 1; k <= 20; k++) begin
`ifdef MUX_SEL_ARB_TIMEOUT_EN
         s  = (k <= 15) ? 3'd0 : 3'd1;
         to = (k == 16) ? 1'b1 : 1'b0;
`else
         s  = 3'd0;
         to = 1'b0;
`endif
         step(8'h03, 1'b0, s, 1'b1, to);
      end
`ifdef MUX_SEL_ARB_TIMEOUT_EN
      step(8'h00, 1'b1, 3'd1, 1'b0, 1'b0);
`else
      step(8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
`endif

      // Drain scoreboard within a bounded number of cycles
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
